regfile_write_arbiter: RTL

Round-robin arbiter that shares the single register-file write port among NREQ requesters (CPU writeback, SHA-256 round engine, nonce loader, host interface). It picks one pending write per cycle, registers it, and drives the 5-bit select that feeds the 5-to-32 write-enable decoder, plus the write data. Register 0 is hardwired to zero: writes to it are acknowledged but never reach the decoder with write enable asserted.

---
 rtl/regfile_write_arbiter.sv | 78 +++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: round-robin arbiter sharing the single register-file
// write port among NREQ requesters. One write granted per cycle, outputs fully
// registered. Writes to register 0 are acknowledged but never enable the decoder.
module regfile_write_arbiter #(
  parameter int NREQ       = 4,
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ*ADDR_WIDTH-1:0] addr_in,
  input  logic [NREQ*DATA_WIDTH-1:0] data_in,
  input  logic                       hold,
  output logic [NREQ-1:0]            ack,
  output logic                       wr_en,
  output logic [ADDR_WIDTH-1:0]      wr_select,
  output logic [DATA_WIDTH-1:0]      wr_data
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PTR_W-1:0]      ptr;
  logic [PTR_W-1:0]      ptr_next;
  logic [PTR_W-1:0]      cand;
  logic [PTR_W-1:0]      grant_idx;
  logic                  grant_valid;
  logic                  grant;
  logic [NREQ-1:0]       elig;
  logic [NREQ-1:0]       grant_onehot;
  logic [ADDR_WIDTH-1:0] grant_addr;
  logic [DATA_WIDTH-1:0] grant_data;

  // Round-robin search of the eligible set starting at ptr, plus winner muxing.
  // A requester whose ack is currently high is masked so a held request
  // cannot be granted on consecutive cycles.
  always_comb begin
    elig         = req & ~ack;
    grant_valid  = 1'b0;
    grant_idx    = '0;
    cand         = '0;
    grant_onehot = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = PTR_W'((32'(ptr) + k) % 32'(NREQ));
      if (!grant_valid && elig[cand]) begin
        grant_valid = 1'b1;
        grant_idx   = cand;
      end
    end
    grant                   = grant_valid && !hold;
    grant_onehot[grant_idx] = 1'b1;
    grant_addr = addr_in[32'(grant_idx) * ADDR_WIDTH +: ADDR_WIDTH];
    grant_data = data_in[32'(grant_idx) * DATA_WIDTH +: DATA_WIDTH];
    ptr_next   = PTR_W'((32'(grant_idx) + 32'd1) % 32'(NREQ));
  end

  // Register the granted write and advance the pointer past the winner.
  // Without a grant only ack/wr_en clear; select and data keep their values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ptr       <= '0;
      ack       <= '0;
      wr_en     <= 1'b0;
      wr_select <= '0;
      wr_data   <= '0;
    end else if (grant) begin
      ptr       <= ptr_next;
      ack       <= grant_onehot;
      wr_en     <= |grant_addr;
      wr_select <= grant_addr;
      wr_data   <= grant_data;
    end else begin
      ack       <= '0;
      wr_en     <= 1'b0;
    end
  end

endmodule
